driver_display_7seg: RTL and testbench
======================================

// Module: driver_display_7seg
// PURPOSE
// - Time-multiplexed hex driver for the board's common-anode 7-segment display.
// - Consumes SALIDA of the operand/result display mux (A, B or result per calc state).
// - Shows the value as in_length/4 hex digits, one digit at a time, at a programmable refresh rate.
// - Snapshots the value once per scan frame, so a digit never changes mid-frame.
// PARAMETERS
// - in_length   16     Input value width. Multiple of 4; N_DIGITS = in_length/4.
// - COUNT_MAX   50000  CLK cycles per digit slot (prescaler period). >= 2.
// PORTS
// - CLK          in   1            System clock; all logic on posedge.
// - RESET        in   1            Synchronous, active-high reset.
// - VALOR        in   in_length    Value to display (from display mux SALIDA).
// - BLANK_ZEROS  in   1            1 = suppress leading zero digits.
// - AN           out  N_DIGITS     Digit enables, active-low, one-hot-low when lit.
// - SEG          out  7            Segments {g,f,e,d,c,b,a}, active-low.
// - DP           out  1            Decimal point, active-low; always 1 (off).
// - FRAME        out  1            1-cycle pulse when a new snapshot of VALOR is taken.
// BEHAVIOUR
// - Reset: cnt=0, idx=0, shadow=0, AN=all 1, SEG=7'h7F, DP=1, FRAME=0.
// - Prescaler: cnt counts 0..COUNT_MAX-1 and wraps to 0. tick = (cnt==COUNT_MAX-1).
// - Digit index: on tick, idx increments; N_DIGITS-1 wraps to 0. Digit 0 is the LS nibble.
// - Snapshot: on tick with idx==N_DIGITS-1, shadow<=VALOR and FRAME<=1 on the same edge
//   that idx returns to 0. FRAME is 0 otherwise.
// - VALOR changes between snapshots do not affect output until the next frame.
// - Outputs are registered every cycle from the current idx and shadow, giving 1 cycle of latency.
//   - AN = ~(1<<idx).
//   - SEG = hex decode of shadow[4*idx+:4].
// - First cycle after RESET deasserts: AN=~1 and SEG shows '0'. Shadow=0 until the first snapshot.
// - Blanking: if BLANK_ZEROS=1, idx>0, and shadow nibbles idx..N_DIGITS-1 are all zero,
//   then AN=all 1 and SEG=7'h7F for that slot. Digit 0 is never blanked.
//   BLANK_ZEROS is used live, with no snapshot.
// - Decode, active-low {g..a}:
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//   8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
// - RESET mid-frame: all state returns to reset values on the next edge.
//   The in-progress frame is abandoned and no FRAME pulse is issued.
// - Frame period: N_DIGITS*COUNT_MAX cycles. The first snapshot comes N_DIGITS*COUNT_MAX cycles
//   after reset release.
// - No combinational path from any input to any output.
// TESTING (COUNT_MAX=4, in_length=16)
// - Reset held 3 cycles, VALOR=16'h1234.
//   -> AN=4'b1111, SEG=7'h7F, FRAME=0 during reset.
//   -> First post-reset cycle AN=4'b1110, SEG=1000000.
// - VALOR=16'h1234 steady after reset.
//   -> FRAME pulses at cycle 16 after release, one cycle wide.
//   -> Next frame scans AN 1110/1101/1011/0111 for 4 cycles each.
//   -> SEG is 4,3,2,1 patterns (0011001,0110000,0100100,1111001).
// - Snapshot hold: VALOR changes 16'h1234->16'hABCD mid-frame.
//   -> Displayed digits stay 1234 until the next FRAME, then show D,C,b,A.
// - Blanking: BLANK_ZEROS=1, VALOR=16'h0050.
//   -> Digits 3 and 2 give AN=1111, SEG=7'h7F. Digit 1 shows '5'. Digit 0 shows '0'.
//   -> Same with VALOR=0: only digit 0 lit, showing '0'.
// - Blanking off: BLANK_ZEROS=0, VALOR=16'h00F0.
//   -> All four digits lit: 0,F,0,0 from LS to MS.
// - Reset mid-frame: assert RESET at idx=2.
//   -> Next edge gives reset outputs. After release the scan restarts at idx 0 with shadow=0.
//   -> No FRAME pulse occurs until 16 cycles later.

Source files
------------

// File: rtl/driver_display_7seg_if.sv
// Bus between the display value source and the multiplexed 7-segment driver.
// The master presents the value and blanking mode; the slave drives the digit and segment lines.
interface driver_display_7seg_if #(
    parameter int unsigned in_length = 16
);
    localparam int unsigned N_DIGITS = in_length / 4;

    logic [in_length-1:0] valor;
    logic                 blank_zeros;
    logic [N_DIGITS-1:0]  an;
    logic [6:0]           seg;
    logic                 dp;
    logic                 frame;

    modport master (
        output valor,
        output blank_zeros,
        input  an,
        input  seg,
        input  dp,
        input  frame
    );

    modport slave (
        input  valor,
        input  blank_zeros,
        output an,
        output seg,
        output dp,
        output frame
    );
endinterface

// File: rtl/driver_display_7seg.sv
// Time-multiplexed hex driver for a common-anode 7-segment display.
// The value is latched once per scan frame so a digit never changes mid-frame.
module driver_display_7seg #(
    parameter int unsigned in_length = 16,
    parameter int unsigned COUNT_MAX = 50000
) (
    input logic                  clk,
    input logic                  reset,
    driver_display_7seg_if.slave bus
);
    localparam int unsigned N_DIGITS = in_length / 4;
    localparam int unsigned CNT_W    = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned SEG_W    = 7;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(COUNT_MAX - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [SEG_W-1:0]    SEG_OFF  = 7'h7F;
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{1'b1}};

    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [in_length-1:0] shadow;
    logic                 tick;
    logic                 frame_end;

    logic [3:0]           digit_nib;
    logic                 upper_zero;
    logic                 blank;
    logic [N_DIGITS-1:0]  an_nxt;
    logic [SEG_W-1:0]     seg_nxt;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    // Prescaler, digit index and per-frame value snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            if (frame_end) begin
                shadow <= bus.valor;
            end
        end
    end

    // Select the current nibble and decide whether it is a suppressed leading zero.
    always_comb begin
        digit_nib  = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (IDX_W'(i) == idx) begin
                digit_nib = shadow[4*i +: 4];
            end
            if ((i >= int'(idx)) && (shadow[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = bus.blank_zeros && (idx != '0) && upper_zero;

        an_nxt  = ~(N_DIGITS'(1) << idx);
        seg_nxt = hex_to_seg(digit_nib);
        if (blank) begin
            an_nxt  = AN_OFF;
            seg_nxt = SEG_OFF;
        end
    end

    // Output registers: one cycle behind the index/shadow state.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.an    <= AN_OFF;
            bus.seg   <= SEG_OFF;
            bus.dp    <= 1'b1;
            bus.frame <= 1'b0;
        end else begin
            bus.an    <= an_nxt;
            bus.seg   <= seg_nxt;
            bus.dp    <= 1'b1;
            bus.frame <= frame_end;
        end
    end
endmodule

// File: tb/tb_driver_display_7seg.sv
// Scoreboard bench for the multiplexed 7-segment driver.
// A cycle-count reference model predicts each registered output; a monitor compares on negedge.
module tb_driver_display_7seg;
    localparam int unsigned IN_LEN    = 16;
    localparam int unsigned CM        = 4;
    localparam int unsigned ND        = IN_LEN / 4;
    localparam int unsigned FRAME_LEN = ND * CM;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    driver_display_7seg_if #(.in_length(IN_LEN)) bus ();

    driver_display_7seg #(
        .in_length(IN_LEN),
        .COUNT_MAX(CM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          since  = 0;
    logic [15:0] shadow_m = 16'h0000;
    int          frames_seen = 0;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tbl[v];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the output after each edge reflects which slot of the frame
    // the previous cycle belonged to and the value latched at the last frame boundary.
    always @(posedge clk) begin : model
        exp_t        e;
        int          idx;
        logic [15:0] upper;
        if (reset) begin
            e        = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
            since    = 0;
            shadow_m = 16'h0000;
        end else begin
            idx   = (since / CM) % ND;
            upper = shadow_m >> (4 * idx);
            e.dp  = 1'b1;
            if (bus.blank_zeros && idx != 0 && upper == 16'h0000) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end else begin
                e.an  = ~(4'b0001 << idx);
                e.seg = hex7(upper[3:0]);
            end
            e.frame = ((since + 1) % FRAME_LEN) == 0;
            if (e.frame) shadow_m = bus.valor;
            since++;
        end
        q.push_back(e);
    end

    // Monitor: the DUT presents fresh outputs every cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("an",    int'(bus.an),    int'(e.an));
            check("seg",   int'(bus.seg),   int'(e.seg));
            check("dp",    int'(bus.dp),    int'(e.dp));
            check("frame", int'(bus.frame), int'(e.frame));
            if (bus.frame) frames_seen++;
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        logic [15:0] mask;
        int          guard;
        bus.valor       = 16'h1234;
        bus.blank_zeros = 1'b0;
        reset           = 1'b1;
        run(3);
        reset = 1'b0;
        run(40);

        // Change the value in the middle of a frame.
        bus.valor = 16'hABCD;
        run(40);

        bus.blank_zeros = 1'b1;
        bus.valor       = 16'h0050;
        run(40);
        bus.valor = 16'h0000;
        run(40);
        bus.blank_zeros = 1'b0;
        bus.valor       = 16'h00F0;
        run(40);

        // Reset while slot 2 of a frame is being scanned.
        guard = 0;
        while (((since / CM) % ND) != 2 && guard < 2 * FRAME_LEN) begin
            run(1);
            guard++;
        end
        check("reach_idx2", int'(((since / CM) % ND) == 2), 1);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(40);

        // Randomized value, blanking and occasional reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mask = '0;
                for (int d = 0; d < int'(ND); d++)
                    if ($urandom_range(0, 1) == 1) mask[4*d +: 4] = 4'hF;
                bus.valor = 16'($urandom) & mask;
            end
            if ($urandom_range(0, 15) == 0) bus.blank_zeros = ~bus.blank_zeros;
            reset = ($urandom_range(0, 199) == 0);
            run(1);
        end
        reset = 1'b0;
        run(3);

        #1;
        check("queue_drained", q.size(), 0);
        checks++;
        if (frames_seen < 20) begin
            errors++;
            $display("FAIL frame_count: got %0d expected at least 20", frames_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
